// File: rtl/fix_order_pkg.sv
// Shared types and constants for the FIX New Order Single decoder.
// Optional build macro FIX_ORDER_CLORDID_EN is consumed by fix_order_decoder, not here.
package fix_order_pkg;

   // FIX tags as ASCII, left-padded with NUL bytes
   localparam logic [23:0] TAG_BEGIN   = 24'h000038;
   localparam logic [23:0] TAG_MSGTYPE = 24'h003335;
   localparam logic [23:0] TAG_SIDE    = 24'h003534;
   localparam logic [23:0] TAG_QTY     = 24'h003338;
   localparam logic [23:0] TAG_ORDTYPE = 24'h003430;
   localparam logic [23:0] TAG_PRICE   = 24'h003434;
   localparam logic [23:0] TAG_SYMBOL  = 24'h003535;
   localparam logic [23:0] TAG_CLORDID = 24'h003131;

   localparam logic [7:0] ASCII_NUL = 8'h00;
   localparam logic [7:0] ASCII_0   = 8'h30;
   localparam logic [7:0] ASCII_1   = 8'h31;
   localparam logic [7:0] ASCII_2   = 8'h32;
   localparam logic [7:0] ASCII_9   = 8'h39;
   localparam logic [7:0] ASCII_DOT = 8'h2E;
   localparam logic [7:0] ASCII_D   = 8'h44;

   typedef enum logic [1:0] {
      SIDE_NONE = 2'b00,
      SIDE_BUY  = 2'b01,
      SIDE_SELL = 2'b10
   } side_e;

   typedef enum logic [2:0] {
      ERR_NONE      = 3'd0,
      ERR_MISSING   = 3'd1,
      ERR_BAD_FIELD = 3'd2,
      ERR_CHECKSUM  = 3'd3,
      ERR_TIMEOUT   = 3'd4,
      ERR_ABORT     = 3'd5
   } err_code_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_IN_MSG   = 2'd1,
      ST_WAIT_CHK = 2'd2,
      ST_EMIT     = 2'd3
   } state_e;

endpackage

// File: rtl/fix_ascii_to_uint.sv
// Combinational ASCII decimal to binary converter for one 8-char FIX value.
// Leading NUL padding is skipped; fraction digits beyond MAX_FRAC are validated but dropped.
module fix_ascii_to_uint
   import fix_order_pkg::*;
#(
   parameter int OUT_W     = 32,
   parameter bit ALLOW_DOT = 1'b0,
   parameter int MAX_FRAC  = 2
) (
   input  logic [63:0]      value,
   output logic [OUT_W-1:0] mag,
   output logic [3:0]       frac_digits,
   output logic             bad_char,
   output logic             overflow
);

   logic [63:0] acc;
   logic [7:0]  ch;
   logic        started;
   logic        seen_dot;
   logic        any_digit;

   always_comb begin
      acc         = '0;
      ch          = '0;
      started     = 1'b0;
      seen_dot    = 1'b0;
      any_digit   = 1'b0;
      frac_digits = '0;
      bad_char    = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         ch = value[i*8 +: 8];
         if (ch == ASCII_NUL) begin
            // a NUL after the first character means a hole in the field
            if (started) bad_char = 1'b1;
         end else begin
            started = 1'b1;
            if (ch >= ASCII_0 && ch <= ASCII_9) begin
               any_digit = 1'b1;
               if (!seen_dot) begin
                  acc = acc * 64'd10 + {56'd0, ch - ASCII_0};
               end else if (32'(frac_digits) < MAX_FRAC) begin
                  acc         = acc * 64'd10 + {56'd0, ch - ASCII_0};
                  frac_digits = frac_digits + 4'd1;
               end
            end else if (ALLOW_DOT && ch == ASCII_DOT && !seen_dot) begin
               seen_dot = 1'b1;
            end else begin
               bad_char = 1'b1;
            end
         end
      end
      if (!any_digit) bad_char = 1'b1;
      overflow = |acc[63:OUT_W];
      mag      = overflow ? '1 : acc[OUT_W-1:0];
   end

endmodule

// File: rtl/fix_order_decoder.sv
// Assembles one FIX New Order Single per message and emits a binary order record.
// Build macro FIX_ORDER_CLORDID_EN adds ord_clordid and makes tag 11 a required field.
//
// state     | meaning
// IDLE      | waiting for tag 8 to open a message
// IN_MSG    | capturing fields until checksum_valid
// WAIT_CHK  | checksum seen, waiting up to CHK_TIMEOUT cycles for parser verdict
// EMIT      | verdict accepted; order/error pulse visible this cycle
module fix_order_decoder
   import fix_order_pkg::*;
#(
   parameter int PRICE_FRAC_DIGITS = 2,
   parameter int CHK_TIMEOUT       = 4,
   parameter int QTY_W             = 32,
   parameter int PRICE_W           = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [23:0]        tag,
   input  logic               tag_valid,
   input  logic [63:0]        value,
   input  logic               value_valid,
   input  logic               checksum_valid,
   input  logic               parser_valid,
   input  logic               parser_not_valid,
   output logic               ord_valid,
   output logic [1:0]         ord_side,
   output logic [QTY_W-1:0]   ord_qty,
   output logic [PRICE_W-1:0] ord_price,
   output logic [63:0]        ord_symbol,
   output logic               ord_error,
   output logic [2:0]         ord_err_code
`ifdef FIX_ORDER_CLORDID_EN
   ,
   output logic [63:0]        ord_clordid
`endif
);

   localparam logic [7:0] CNT_INIT = 8'(CHK_TIMEOUT);

   state_e              state, state_nxt;
   logic [7:0]          cnt;
   logic [23:0]         tag_q, cur_tag;
   logic                is_begin, start_msg, capture, load_cnt, judge, emit, err_fire;
   err_code_e           err_code;
   logic                is_order, ordtype2, missing, bad;
   logic                have35, have54, have38, have44, have55;
   logic                bad_side, bad_qty, bad_price;
   side_e               side_q;
   logic [QTY_W-1:0]    qty_q, qty_mag;
   logic [PRICE_W-1:0]  price_q, price_mag, price_val;
   logic [63:0]         symbol_q, price_wide;
   logic [3:0]          qty_frac, price_frac;
   logic                qty_bad, qty_ovf, price_bad, price_ovf_raw, price_ovf;
`ifdef FIX_ORDER_CLORDID_EN
   logic                have11;
   logic [63:0]         clordid_q;
`endif

   fix_ascii_to_uint #(.OUT_W(QTY_W), .ALLOW_DOT(1'b0), .MAX_FRAC(0)) u_qty (
      .value(value), .mag(qty_mag), .frac_digits(qty_frac),
      .bad_char(qty_bad), .overflow(qty_ovf)
   );

   fix_ascii_to_uint #(.OUT_W(PRICE_W), .ALLOW_DOT(1'b1), .MAX_FRAC(PRICE_FRAC_DIGITS)) u_price (
      .value(value), .mag(price_mag), .frac_digits(price_frac),
      .bad_char(price_bad), .overflow(price_ovf_raw)
   );

   // pad missing fraction digits up to the implied decimal point
   always_comb begin
      price_wide = 64'(price_mag);
      for (int i = 0; i < PRICE_FRAC_DIGITS; i++) begin
         if (i >= 32'(price_frac)) price_wide = price_wide * 64'd10;
      end
      price_ovf = price_ovf_raw | (|price_wide[63:PRICE_W]);
      price_val = price_ovf ? '1 : price_wide[PRICE_W-1:0];
   end

   // tag may arrive with or ahead of its value
   assign cur_tag  = tag_valid ? tag : tag_q;
   assign is_begin = value_valid && (cur_tag == TAG_BEGIN);
   assign bad      = bad_side | bad_qty | bad_price;

   always_comb begin
      missing = !(have35 && have54 && have38 && have55) || (ordtype2 && !have44);
`ifdef FIX_ORDER_CLORDID_EN
      missing = missing || !have11;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_msg = 1'b0;
      capture   = 1'b0;
      load_cnt  = 1'b0;
      judge     = 1'b0;
      emit      = 1'b0;
      err_fire  = 1'b0;
      err_code  = ERR_NONE;
      case (state)
         ST_IDLE, ST_EMIT: begin
            state_nxt = ST_IDLE;
            if (is_begin) begin
               state_nxt = ST_IN_MSG;
               start_msg = 1'b1;
            end
         end
         ST_IN_MSG: begin
            if (is_begin) begin
               start_msg = 1'b1;
               err_fire  = 1'b1;
               err_code  = ERR_ABORT;
            end else if (checksum_valid) begin
               if (parser_not_valid) begin
                  err_fire  = 1'b1;
                  err_code  = ERR_CHECKSUM;
                  state_nxt = ST_IDLE;
               end else if (parser_valid) begin
                  judge     = 1'b1;
                  state_nxt = ST_EMIT;
               end else begin
                  load_cnt  = 1'b1;
                  state_nxt = ST_WAIT_CHK;
               end
            end else begin
               capture = value_valid;
            end
         end
         ST_WAIT_CHK: begin
            if (parser_not_valid) begin
               err_fire  = 1'b1;
               err_code  = ERR_CHECKSUM;
               state_nxt = ST_IDLE;
            end else if (parser_valid) begin
               judge     = 1'b1;
               state_nxt = ST_EMIT;
            end else if (cnt <= 8'd1) begin
               err_fire  = 1'b1;
               err_code  = ERR_TIMEOUT;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // a present non-D MsgType is silently dropped; an absent one counts as missing
      if (judge && !(have35 && !is_order)) begin
         if (bad) begin
            err_fire = 1'b1;
            err_code = ERR_BAD_FIELD;
         end else if (missing) begin
            err_fire = 1'b1;
            err_code = ERR_MISSING;
         end else begin
            emit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt          <= '0;
         tag_q        <= '0;
         is_order     <= 1'b0;
         ordtype2     <= 1'b0;
         have35       <= 1'b0;
         have54       <= 1'b0;
         have38       <= 1'b0;
         have44       <= 1'b0;
         have55       <= 1'b0;
         bad_side     <= 1'b0;
         bad_qty      <= 1'b0;
         bad_price    <= 1'b0;
         side_q       <= SIDE_NONE;
         qty_q        <= '0;
         price_q      <= '0;
         symbol_q     <= '0;
         ord_valid    <= 1'b0;
         ord_error    <= 1'b0;
         ord_err_code <= '0;
         ord_side     <= '0;
         ord_qty      <= '0;
         ord_price    <= '0;
         ord_symbol   <= '0;
`ifdef FIX_ORDER_CLORDID_EN
         have11       <= 1'b0;
         clordid_q    <= '0;
         ord_clordid  <= '0;
`endif
      end else begin
         if (tag_valid) tag_q <= tag;
         if (load_cnt) cnt <= CNT_INIT;
         else if (state == ST_WAIT_CHK && cnt != 8'd0) cnt <= cnt - 8'd1;

         ord_valid    <= emit;
         ord_error    <= err_fire;
         ord_err_code <= err_code;
         if (emit) begin
            ord_side   <= side_q;
            ord_qty    <= qty_q;
            ord_price  <= price_q;
            ord_symbol <= symbol_q;
`ifdef FIX_ORDER_CLORDID_EN
            ord_clordid <= clordid_q;
`endif
         end

         if (start_msg) begin
            is_order  <= 1'b0;
            ordtype2  <= 1'b0;
            have35    <= 1'b0;
            have54    <= 1'b0;
            have38    <= 1'b0;
            have44    <= 1'b0;
            have55    <= 1'b0;
            bad_side  <= 1'b0;
            bad_qty   <= 1'b0;
            bad_price <= 1'b0;
            side_q    <= SIDE_NONE;
            qty_q     <= '0;
            price_q   <= '0;
            symbol_q  <= '0;
`ifdef FIX_ORDER_CLORDID_EN
            have11    <= 1'b0;
            clordid_q <= '0;
`endif
         end else if (capture) begin
            case (cur_tag)
               TAG_MSGTYPE: begin
                  have35   <= 1'b1;
                  is_order <= (value == {56'd0, ASCII_D});
               end
               TAG_SIDE: begin
                  have54   <= 1'b1;
                  bad_side <= 1'b0;
                  if (value == {56'd0, ASCII_1})      side_q <= SIDE_BUY;
                  else if (value == {56'd0, ASCII_2}) side_q <= SIDE_SELL;
                  else begin
                     side_q   <= SIDE_NONE;
                     bad_side <= 1'b1;
                  end
               end
               TAG_QTY: begin
                  have38  <= 1'b1;
                  qty_q   <= qty_mag;
                  bad_qty <= qty_bad | qty_ovf | (|qty_frac);
               end
               TAG_ORDTYPE: ordtype2 <= (value == {56'd0, ASCII_2});
               TAG_PRICE: begin
                  have44    <= 1'b1;
                  price_q   <= price_val;
                  bad_price <= price_bad | price_ovf;
               end
               TAG_SYMBOL: begin
                  have55   <= 1'b1;
                  symbol_q <= value;
               end
`ifdef FIX_ORDER_CLORDID_EN
               TAG_CLORDID: begin
                  have11    <= 1'b1;
                  clordid_q <= value;
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fix_order_decoder.sv
// Self-checking bench for fix_order_decoder: vector table plus hand-written corner sequences.
// Works with or without FIX_ORDER_CLORDID_EN (every message carries tag 11).
module tb_fix_order_decoder;
   import fix_order_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] tag;
   logic        tag_valid;
   logic [63:0] value;
   logic        value_valid, checksum_valid, parser_valid, parser_not_valid;
   logic        ord_valid, ord_error;
   logic [1:0]  ord_side;
   logic [31:0] ord_qty, ord_price;
   logic [63:0] ord_symbol;
   logic [2:0]  ord_err_code;
`ifdef FIX_ORDER_CLORDID_EN
   logic [63:0] ord_clordid;
`endif

   always #5 clk = ~clk;

   fix_order_decoder #(.PRICE_FRAC_DIGITS(2), .CHK_TIMEOUT(4), .QTY_W(32), .PRICE_W(32)) dut (
      .clk(clk), .rst(rst), .tag(tag), .tag_valid(tag_valid), .value(value),
      .value_valid(value_valid), .checksum_valid(checksum_valid),
      .parser_valid(parser_valid), .parser_not_valid(parser_not_valid),
      .ord_valid(ord_valid), .ord_side(ord_side), .ord_qty(ord_qty), .ord_price(ord_price),
      .ord_symbol(ord_symbol), .ord_error(ord_error), .ord_err_code(ord_err_code)
`ifdef FIX_ORDER_CLORDID_EN
      , .ord_clordid(ord_clordid)
`endif
   );

   typedef struct {
      int          kind;    // 0 nothing, 1 order, 2 error
      int          cyc;
      logic [2:0]  code;
      logic [1:0]  side;
      logic [31:0] qty;
      logic [31:0] price;
      logic [63:0] sym;
   } exp_t;

   typedef struct {
      string       name;
      string       v35, v54, v38, v40, v44, v55;   // "" = field omitted
      int          verdict;  // 0 valid, 1 not_valid, 2 both, 3 valid with checksum
      int          kind;
      logic [2:0]  code;
      logic [1:0]  side;
      logic [31:0] qty;
      logic [31:0] price;
      logic [63:0] sym;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[15];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] asc(string s);
      logic [63:0] r = '0;
      for (int i = 0; i < s.len(); i++) r = {r[55:0], s[i]};
      return r;
   endfunction

   function automatic logic [23:0] tg(string s);
      logic [23:0] r = '0;
      for (int i = 0; i < s.len(); i++) r = {r[15:0], s[i]};
      return r;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b1 && (ord_valid || ord_error)) begin
         chk("exclusive", {63'd0, ord_valid & ord_error}, 64'd0);
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {62'd0, ord_valid, ord_error}, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("pulse_kind", {62'd0, ord_valid, ord_error}, (e.kind == 1) ? 64'd2 : 64'd1);
            chk("latency", 64'(cyc), 64'(e.cyc));
            if (e.kind == 1) begin
               chk("side", {62'd0, ord_side}, {62'd0, e.side});
               chk("qty", {32'd0, ord_qty}, {32'd0, e.qty});
               chk("price", {32'd0, ord_price}, {32'd0, e.price});
               chk("symbol", ord_symbol, e.sym);
            end else begin
               chk("err_code", {61'd0, ord_err_code}, {61'd0, e.code});
            end
         end
      end
   end

   task automatic idle();
      tag = '0; value = '0; tag_valid = 1'b0; value_valid = 1'b0;
      checksum_valid = 1'b0; parser_valid = 1'b0; parser_not_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic pair(string t, string v);
      tag = tg(t); value = asc(v); tag_valid = 1'b1; value_valid = 1'b1;
      step();
   endtask

   task automatic push(vec_t v, int at);
      if (v.kind != 0) sb.push_back('{v.kind, at, v.code, v.side, v.qty, v.price, v.sym});
   endtask

   task automatic send_body(vec_t v, bit with_begin);
      if (with_begin) pair("8", "FIX.4.2");
      pair("9", "144");
      if (v.v35 != "") pair("35", v.v35);
      pair("34", "2");
      pair("49", "CLIENT1");
      pair("52", "20240101");
      pair("56", "ORDERMATCH");
      pair("11", "ORD00042");
      pair("21", "1");
      if (v.v38 != "") pair("38", v.v38);
      if (v.v40 != "") pair("40", v.v40);
      if (v.v44 != "") pair("44", v.v44);
      if (v.v54 != "") pair("54", v.v54);
      if (v.v55 != "") pair("55", v.v55);
      pair("59", "0");
      pair("60", "120000");
   endtask

   task automatic finish_msg(vec_t v);
      tag = tg("10"); value = asc("180"); checksum_valid = 1'b1;
      if (v.verdict == 3) begin
         parser_valid = 1'b1;
         push(v, cyc + 1);
         step();
      end else begin
         step();
         push(v, cyc + 1);
         parser_valid     = (v.verdict == 0) || (v.verdict == 2);
         parser_not_valid = (v.verdict == 1) || (v.verdict == 2);
         step();
      end
   endtask

   task automatic drain(string name);
      repeat (3) step();
      chk(name, 64'(sb.size()), 64'd0);
   endtask

   task automatic run_vec(vec_t v);
      send_body(v, 1'b1);
      finish_msg(v);
      drain(v.name);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cs;
      vecs[0]  = '{"full",      "D", "1", "98",       "2", "102.7", "IBM",  0, 1, 3'd0, 2'b01, 32'd98,       32'd10270, 64'h49424D};
      vecs[1]  = '{"notvalid",  "D", "1", "98",       "2", "102.7", "IBM",  1, 2, 3'd3, 2'b00, 32'd0,        32'd0,     64'h0};
      vecs[2]  = '{"no44_ord2", "D", "1", "98",       "2", "",      "IBM",  0, 2, 3'd1, 2'b00, 32'd0,        32'd0,     64'h0};
      vecs[3]  = '{"no44_ord1", "D", "1", "98",       "1", "",      "IBM",  0, 1, 3'd0, 2'b01, 32'd98,       32'd0,     64'h49424D};
      vecs[4]  = '{"side3",     "D", "3", "98",       "2", "102.7", "IBM",  0, 2, 3'd2, 2'b00, 32'd0,        32'd0,     64'h0};
      vecs[5]  = '{"qty9A",     "D", "1", "9A",       "2", "102.7", "IBM",  0, 2, 3'd2, 2'b00, 32'd0,        32'd0,     64'h0};
      vecs[6]  = '{"both",      "D", "1", "98",       "2", "102.7", "IBM",  2, 2, 3'd3, 2'b00, 32'd0,        32'd0,     64'h0};
      vecs[7]  = '{"sell",      "D", "2", "12345678", "2", "5",     "MSFT", 0, 1, 3'd0, 2'b10, 32'd12345678, 32'd500,   64'h4D534654};
      vecs[8]  = '{"trunc",     "D", "1", "7",        "2", "1.239", "AAPL", 0, 1, 3'd0, 2'b01, 32'd7,        32'd123,   64'h4141504C};
      vecs[9]  = '{"twodots",   "D", "1", "98",       "2", "1.2.3", "IBM",  0, 2, 3'd2, 2'b00, 32'd0,        32'd0,     64'h0};
      vecs[10] = '{"samecyc",   "D", "1", "98",       "2", "102.7", "IBM",  3, 1, 3'd0, 2'b01, 32'd98,       32'd10270, 64'h49424D};
      vecs[11] = '{"no35",      "",  "1", "98",       "2", "102.7", "IBM",  0, 2, 3'd1, 2'b00, 32'd0,        32'd0,     64'h0};
      vecs[12] = '{"no55",      "D", "1", "98",       "2", "102.7", "",     0, 2, 3'd1, 2'b00, 32'd0,        32'd0,     64'h0};
      vecs[13] = '{"heartbeat", "0", "1", "98",       "2", "102.7", "IBM",  0, 0, 3'd0, 2'b00, 32'd0,        32'd0,     64'h0};
      vecs[14] = '{"no38",      "D", "1", "",         "2", "102.7", "IBM",  0, 2, 3'd1, 2'b00, 32'd0,        32'd0,     64'h0};

      rst = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {63'd0, ord_valid}, 64'd0);
      chk("rst_error", {63'd0, ord_error}, 64'd0);
      chk("rst_record", {ord_qty, ord_price} | ord_symbol | {59'd0, ord_side, ord_err_code}, 64'd0);
      rst = 1'b1;
      step();

      for (int i = 0; i < 15; i++) run_vec(vecs[i]);

      // heartbeat followed immediately by an order
      send_body(vecs[13], 1'b1);
      finish_msg(vecs[13]);
      run_vec(vecs[0]);

      // record holds through a rejected message
      run_vec(vecs[5]);
      chk("hold_qty", {32'd0, ord_qty}, 64'd98);
      chk("hold_price", {32'd0, ord_price}, 64'd10270);
      chk("hold_symbol", ord_symbol, 64'h49424D);

      // new tag 8 aborts; fields of the aborted message must not leak
      pair("8", "FIX.4.2");
      pair("35", "D");
      pair("55", "XYZ");
      sb.push_back('{2, cyc + 1, 3'd5, 2'b00, 32'd0, 32'd0, 64'h0});
      pair("8", "FIX.4.2");
      send_body(vecs[12], 1'b0);
      finish_msg(vecs[12]);
      drain("abort");

      // verdict timeout
      send_body(vecs[0], 1'b1);
      tag = tg("10"); value = asc("180"); checksum_valid = 1'b1;
      cs = cyc;
      step();
      sb.push_back('{2, cs + 5, 3'd4, 2'b00, 32'd0, 32'd0, 64'h0});
      repeat (4) step();
      drain("timeout");

      // verdict on the last cycle of the window is still honoured
      send_body(vecs[7], 1'b1);
      tag = tg("10"); value = asc("180"); checksum_valid = 1'b1;
      step();
      repeat (3) step();
      push(vecs[7], cyc + 1);
      parser_valid = 1'b1;
      step();
      drain("late_verdict");

      // stray verdicts while idle are ignored
      parser_valid = 1'b1;
      step();
      parser_not_valid = 1'b1;
      step();
      drain("idle_verdict");

      // asynchronous reset mid-field
      pair("8", "FIX.4.2");
      pair("35", "D");
      pair("54", "1");
      tag = tg("38"); value = asc("9"); tag_valid = 1'b1; value_valid = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("arst_pulses", {62'd0, ord_valid, ord_error}, 64'd0);
      chk("arst_qty_price", {ord_qty, ord_price}, 64'd0);
      chk("arst_symbol", ord_symbol, 64'd0);
      chk("arst_side_code", {59'd0, ord_side, ord_err_code}, 64'd0);
      step();
      rst = 1'b1;
      tag = tg("10"); checksum_valid = 1'b1; parser_valid = 1'b1;
      step();
      drain("arst_idle");
      run_vec(vecs[7]);

      chk("queue_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
